// File: rtl/serial_pattern_cmd_ctrl.sv
// UART command decoder: gathers a fixed-length packet, dispatches a load/stop strobe
// to one serial-out channel, and answers every packet with a single acknowledge byte.
`timescale 1ns/1ps
module serial_pattern_cmd_ctrl #(
  parameter int PACK_NUM    = 9,
  parameter int DATA_BIT    = 32,
  parameter int CH_NUM      = 16,
  parameter int TIMEOUT_CLK = 20000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          i_data,
  input  logic                i_rx_done_tick,
  input  logic [CH_NUM-1:0]   i_busy,
  output logic [CH_NUM-1:0]   o_load,
  output logic [CH_NUM-1:0]   o_stop,
  output logic [DATA_BIT-1:0] o_out_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_mode,
  output logic                o_tx_start,
  output logic [7:0]          o_tx_data,
  input  logic                i_tx_done_tick,
  output logic                o_err_tick
);

  localparam int CNT_W = $clog2(PACK_NUM + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLK + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK_NUM);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLK - 1);
  localparam logic [4:0]       CH_LIM   = 5'((CH_NUM > 16) ? 16 : CH_NUM);

  typedef enum logic [2:0] {
    IDLE, RECV, DECODE, WAIT_CH, DISPATCH, ACK, ACK_WAIT
  } state_t;

  state_t             r_state;
  logic [7:0]         r_pkt [PACK_NUM];
  logic [CNT_W-1:0]   r_cnt;
  logic [TO_W-1:0]    r_to;

  logic               w_store;
  logic [CNT_W-1:0]   w_idx;
  logic [7:0]         w_ctrl;
  logic [3:0]         w_ch;
  logic               w_bad;
  logic               w_is_stop;
  logic               w_late_byte;
  logic [CH_NUM-1:0]  w_sel;
  logic [DATA_BIT-1:0] w_out;
  logic [DATA_BIT-1:0] w_freq;

  // The packet buffer is frozen from DECODE onward because late bytes are never stored,
  // so the control byte can be decoded combinationally in every later state.
  assign w_store     = i_rx_done_tick &&
                       ((r_state == IDLE) || ((r_state == RECV) && (r_cnt != CNT_FULL)));
  assign w_idx       = (r_state == IDLE) ? '0 : r_cnt;
  assign w_ctrl      = r_pkt[PACK_NUM-1];
  assign w_ch        = w_ctrl[7:4];
  assign w_is_stop   = (w_ctrl[1:0] == 2'b10);
  assign w_bad       = w_ctrl[3] || (w_ctrl[1:0] == 2'b00) || (w_ctrl[1:0] == 2'b11) ||
                       ({1'b0, w_ch} >= CH_LIM);
  assign w_sel       = CH_NUM'(1) << w_ch;
  assign w_out       = DATA_BIT'({r_pkt[3], r_pkt[2], r_pkt[1], r_pkt[0]});
  assign w_freq      = DATA_BIT'({r_pkt[7], r_pkt[6], r_pkt[5], r_pkt[4]});
  assign w_late_byte = i_rx_done_tick && (r_state != IDLE) && (r_state != RECV);

  always_ff @(posedge clk) begin
    if (w_store) r_pkt[w_idx] <= i_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_to           <= '0;
      o_load         <= '0;
      o_stop         <= '0;
      o_out_pattern  <= '0;
      o_freq_pattern <= '0;
      o_mode         <= 1'b0;
      o_tx_start     <= 1'b0;
      o_tx_data      <= '0;
      o_err_tick     <= 1'b0;
    end else begin
      o_load     <= '0;
      o_stop     <= '0;
      o_tx_start <= 1'b0;
      o_err_tick <= w_late_byte;
      case (r_state)
        IDLE: begin
          if (i_rx_done_tick) begin
            r_cnt   <= CNT_W'(1);
            r_to    <= '0;
            r_state <= RECV;
          end
        end
        RECV: begin
          if (r_cnt == CNT_FULL) begin
            if (i_rx_done_tick) o_err_tick <= 1'b1;
            r_state <= DECODE;
          end else if (i_rx_done_tick) begin
            r_cnt <= r_cnt + 1'b1;
            r_to  <= '0;
          end else if (r_to == TO_LAST) begin
            o_err_tick <= 1'b1;
            r_cnt      <= '0;
            r_to       <= '0;
            r_state    <= IDLE;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        DECODE: begin
          r_cnt <= '0;
          r_to  <= '0;
          if (w_bad) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= {4'hE, w_ch};
            r_state    <= ACK;
          end else if (w_is_stop) begin
            o_stop         <= w_sel;
            o_out_pattern  <= w_out;
            o_freq_pattern <= w_freq;
            o_mode         <= w_ctrl[2];
            r_state        <= DISPATCH;
          end else begin
            r_state <= WAIT_CH;
          end
        end
        WAIT_CH: begin
          if (!i_busy[w_ch]) begin
            o_load         <= w_sel;
            o_out_pattern  <= w_out;
            o_freq_pattern <= w_freq;
            o_mode         <= w_ctrl[2];
            r_state        <= DISPATCH;
          end
        end
        DISPATCH: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= {4'hA, w_ch};
          r_state    <= ACK;
        end
        ACK: begin
          r_state <= ACK_WAIT;
        end
        ACK_WAIT: begin
          if (i_tx_done_tick) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_cmd_ctrl.sv
// Directed bench for serial_pattern_cmd_ctrl: packet decode, strobes, acks, timeout,
// busy back-pressure, late-byte rejection and reset mid-transaction.
`timescale 1ns/1ps
module tb_serial_pattern_cmd_ctrl;

  localparam int TO = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_rx_done_tick = 1'b0;
  logic [15:0] i_busy = '0;
  logic [15:0] o_load, o_stop;
  logic [31:0] o_out_pattern, o_freq_pattern;
  logic        o_mode, o_tx_start, o_err_tick;
  logic [7:0]  o_tx_data;
  logic        i_tx_done_tick = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_last = 0;
  int t_inj = 0;

  int load_n = 0, stop_n = 0, tx_n = 0, err_n = 0, both_n = 0, unstable_n = 0;
  int load_cyc = 0, stop_cyc = 0, tx_cyc = 0, err_cyc = 0;
  logic [15:0] load_val = '0, stop_val = '0;
  logic [31:0] out_val = '0, freq_val = '0;
  logic        mode_val = 1'b0;
  logic [7:0]  tx_val = '0;
  logic        in_ack = 1'b0;

  serial_pattern_cmd_ctrl #(.PACK_NUM(9), .DATA_BIT(32), .CH_NUM(16), .TIMEOUT_CLK(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_rx_done_tick(i_rx_done_tick),
    .i_busy(i_busy), .o_load(o_load), .o_stop(o_stop), .o_out_pattern(o_out_pattern),
    .o_freq_pattern(o_freq_pattern), .o_mode(o_mode), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .i_tx_done_tick(i_tx_done_tick), .o_err_tick(o_err_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_load != 0) begin
      load_n++; load_val = o_load; load_cyc = cyc;
      out_val = o_out_pattern; freq_val = o_freq_pattern; mode_val = o_mode;
    end
    if (o_stop != 0) begin
      stop_n++; stop_val = o_stop; stop_cyc = cyc;
      out_val = o_out_pattern; freq_val = o_freq_pattern; mode_val = o_mode;
    end
    if (o_load != 0 && o_stop != 0) both_n++;
    if (o_err_tick) begin err_n++; err_cyc = cyc; end
    if (o_tx_start) begin
      tx_n++; tx_val = o_tx_data; tx_cyc = cyc; in_ack = 1'b1;
    end else if (in_ack && o_tx_data !== tx_val) begin
      unstable_n++;
    end
    if (i_tx_done_tick) in_ack = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data = b; i_rx_done_tick = 1'b1;
    @(posedge clk); #1;
    i_rx_done_tick = 1'b0;
    t_last = cyc;
  endtask

  task automatic send_pkt(input logic [71:0] p);
    for (int i = 0; i < 9; i++) send_byte(p[71-8*i -: 8]);
  endtask

  task automatic do_ack(input int tx0, input bit inject);
    int k;
    k = 0;
    while (tx_n == tx0 && k < 2000) begin step(1); k++; end
    vectors++;
    if (tx_n == tx0) begin
      miscompares++; $display("FAIL ack_wait no o_tx_start within %0d cycles", k);
    end
    step(2);
    if (inject) begin send_byte(8'hC3); t_inj = cyc; end
    step(2);
    i_tx_done_tick = 1'b1; step(1); i_tx_done_tick = 1'b0;
    step(2);
  endtask

  task automatic pulse_reset;
    rst_n = 1'b1; step(1); rst_n = 1'b0; step(1);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b1;
    i_data = 8'hAA; i_rx_done_tick = 1'b1;
    step(3);
    vectors++; if (o_load !== 16'h0) begin miscompares++; $display("FAIL rst_load got %h want 0", o_load); end
    vectors++; if (o_stop !== 16'h0) begin miscompares++; $display("FAIL rst_stop got %h want 0", o_stop); end
    vectors++; if (o_out_pattern !== 32'h0) begin miscompares++; $display("FAIL rst_out got %h want 0", o_out_pattern); end
    vectors++; if (o_freq_pattern !== 32'h0) begin miscompares++; $display("FAIL rst_freq got %h want 0", o_freq_pattern); end
    vectors++; if (o_mode !== 1'b0) begin miscompares++; $display("FAIL rst_mode got %b want 0", o_mode); end
    vectors++; if (o_tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_txstart got %b want 0", o_tx_start); end
    vectors++; if (o_tx_data !== 8'h0) begin miscompares++; $display("FAIL rst_txdata got %h want 0", o_tx_data); end
    vectors++; if (o_err_tick !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", o_err_tick); end
    i_rx_done_tick = 1'b0;
    rst_n = 1'b0;
    step(3);
  endtask

  task automatic test_load;
    int l0, s0, x0, u0;
    l0 = load_n; s0 = stop_n; x0 = tx_n; u0 = unstable_n;
    send_pkt(72'h55_00_55_00_00_00_00_00_15);
    do_ack(x0, 1'b0);
    vectors++; if (load_n - l0 != 1) begin miscompares++; $display("FAIL load_count got %0d want 1", load_n - l0); end
    vectors++; if (load_val !== 16'h0002) begin miscompares++; $display("FAIL load_val got %h want 0002", load_val); end
    vectors++; if (out_val !== 32'h00550055) begin miscompares++; $display("FAIL load_out got %h want 00550055", out_val); end
    vectors++; if (freq_val !== 32'h0) begin miscompares++; $display("FAIL load_freq got %h want 0", freq_val); end
    vectors++; if (mode_val !== 1'b1) begin miscompares++; $display("FAIL load_mode got %b want 1", mode_val); end
    vectors++; if (stop_n != s0) begin miscompares++; $display("FAIL load_nostop got %0d want 0", stop_n - s0); end
    vectors++; if (tx_val !== 8'hA1) begin miscompares++; $display("FAIL load_ack got %h want A1", tx_val); end
    vectors++; if (load_cyc - t_last != 3) begin miscompares++; $display("FAIL load_latency got %0d want 3", load_cyc - t_last); end
    vectors++; if (tx_cyc - t_last != 4) begin miscompares++; $display("FAIL ack_latency got %0d want 4", tx_cyc - t_last); end
    vectors++; if (o_out_pattern !== 32'h00550055) begin miscompares++; $display("FAIL load_hold got %h want 00550055", o_out_pattern); end
    vectors++; if (unstable_n != u0) begin miscompares++; $display("FAIL ack_stable got %0d changes want 0", unstable_n - u0); end
  endtask

  task automatic test_stop;
    int l0, s0, x0;
    l0 = load_n; s0 = stop_n; x0 = tx_n;
    send_pkt(72'h55_00_55_00_00_00_00_00_F6);
    do_ack(x0, 1'b0);
    vectors++; if (stop_n - s0 != 1) begin miscompares++; $display("FAIL stop_count got %0d want 1", stop_n - s0); end
    vectors++; if (stop_val !== 16'h8000) begin miscompares++; $display("FAIL stop_val got %h want 8000", stop_val); end
    vectors++; if (load_n != l0) begin miscompares++; $display("FAIL stop_noload got %0d want 0", load_n - l0); end
    vectors++; if (tx_val !== 8'hAF) begin miscompares++; $display("FAIL stop_ack got %h want AF", tx_val); end
  endtask

  task automatic test_bad_ctrl;
    logic [7:0] ctrl [3];
    logic [7:0] exp_ack [3];
    int l0, s0, x0;
    ctrl = '{8'h2D, 8'h13, 8'h50};
    exp_ack = '{8'hE2, 8'hE1, 8'hE5};
    for (int i = 0; i < 3; i++) begin
      l0 = load_n; s0 = stop_n; x0 = tx_n;
      send_pkt({64'h01_02_03_04_05_06_07_08, ctrl[i]});
      do_ack(x0, 1'b0);
      vectors++; if (load_n != l0 || stop_n != s0) begin miscompares++; $display("FAIL bad_nostrobe ctrl %h got %0d strobes want 0", ctrl[i], (load_n - l0) + (stop_n - s0)); end
      vectors++; if (tx_val !== exp_ack[i]) begin miscompares++; $display("FAIL bad_ack ctrl %h got %h want %h", ctrl[i], tx_val, exp_ack[i]); end
      vectors++; if (o_out_pattern !== 32'h00550055) begin miscompares++; $display("FAIL bad_hold ctrl %h got %h want 00550055", ctrl[i], o_out_pattern); end
    end
  endtask

  task automatic test_timeout;
    int e0, x0, l0, k;
    e0 = err_n; x0 = tx_n; l0 = load_n;
    for (int i = 0; i < 5; i++) send_byte(8'h11 * (i + 1));
    k = 0;
    while (err_n == e0 && k < TO + 20) begin step(1); k++; end
    step(5);
    vectors++; if (err_n - e0 != 1) begin miscompares++; $display("FAIL to_err_count got %0d want 1", err_n - e0); end
    vectors++; if (err_cyc - t_last != TO) begin miscompares++; $display("FAIL to_delay got %0d want %0d", err_cyc - t_last, TO); end
    vectors++; if (tx_n != x0 || load_n != l0) begin miscompares++; $display("FAIL to_noack got %0d acks want 0", tx_n - x0); end
    x0 = tx_n; l0 = load_n;
    send_pkt(72'h44_33_22_11_AA_BB_CC_DD_71);
    do_ack(x0, 1'b0);
    vectors++; if (load_n - l0 != 1 || load_val !== 16'h0080) begin miscompares++; $display("FAIL to_next_load got %h want 0080", load_val); end
    vectors++; if (out_val !== 32'h11223344) begin miscompares++; $display("FAIL to_next_out got %h want 11223344", out_val); end
    vectors++; if (freq_val !== 32'hDDCCBBAA) begin miscompares++; $display("FAIL to_next_freq got %h want DDCCBBAA", freq_val); end
    vectors++; if (mode_val !== 1'b0) begin miscompares++; $display("FAIL to_next_mode got %b want 0", mode_val); end
    vectors++; if (tx_val !== 8'hA7) begin miscompares++; $display("FAIL to_next_ack got %h want A7", tx_val); end
  endtask

  task automatic test_busy;
    int l0, x0, drop;
    l0 = load_n; x0 = tx_n;
    i_busy = 16'h0008;
    send_pkt(72'h78_56_34_12_F0_0F_F0_0F_35);
    step(500);
    vectors++; if (load_n != l0 || tx_n != x0) begin miscompares++; $display("FAIL busy_hold got %0d loads want 0", load_n - l0); end
    i_busy = 16'h0000;
    drop = cyc;
    do_ack(x0, 1'b0);
    vectors++; if (load_n - l0 != 1 || load_val !== 16'h0008) begin miscompares++; $display("FAIL busy_load got %h want 0008", load_val); end
    vectors++; if (load_cyc - drop != 1) begin miscompares++; $display("FAIL busy_latency got %0d want 1", load_cyc - drop); end
    vectors++; if (out_val !== 32'h12345678 || freq_val !== 32'h0FF00FF0) begin miscompares++; $display("FAIL busy_patterns got %h/%h want 12345678/0FF00FF0", out_val, freq_val); end
    vectors++; if (tx_val !== 8'hA3) begin miscompares++; $display("FAIL busy_ack got %h want A3", tx_val); end
  endtask

  task automatic test_inject;
    int e0, x0, l0;
    e0 = err_n; x0 = tx_n;
    send_pkt(72'h01_02_03_04_05_06_07_08_51);
    do_ack(x0, 1'b1);
    vectors++; if (err_n - e0 != 1) begin miscompares++; $display("FAIL inj_err_count got %0d want 1", err_n - e0); end
    vectors++; if (err_cyc != t_inj) begin miscompares++; $display("FAIL inj_err_cycle got %0d want %0d", err_cyc, t_inj); end
    x0 = tx_n; l0 = load_n;
    send_pkt(72'h0A_0B_0C_0D_00_00_00_00_91);
    do_ack(x0, 1'b0);
    vectors++; if (load_n - l0 != 1 || load_val !== 16'h0200) begin miscompares++; $display("FAIL inj_next_load got %h want 0200", load_val); end
    vectors++; if (out_val !== 32'h0D0C0B0A) begin miscompares++; $display("FAIL inj_next_out got %h want 0D0C0B0A", out_val); end
    vectors++; if (tx_val !== 8'hA9) begin miscompares++; $display("FAIL inj_next_ack got %h want A9", tx_val); end
  endtask

  task automatic test_reset_mid;
    int l0, x0;
    l0 = load_n; x0 = tx_n;
    i_busy = 16'h0008;
    send_pkt(72'h11_11_11_11_22_22_22_22_31);
    step(10);
    pulse_reset;
    i_busy = 16'h0000;
    step(20);
    vectors++; if (load_n != l0 || tx_n != x0) begin miscompares++; $display("FAIL rst_waitch got %0d loads %0d acks want 0", load_n - l0, tx_n - x0); end
    for (int i = 0; i < 4; i++) send_byte(8'h99);
    pulse_reset;
    step(20);
    vectors++; if (tx_n != x0) begin miscompares++; $display("FAIL rst_partial got %0d acks want 0", tx_n - x0); end
    send_pkt(72'hEE_DD_CC_BB_00_00_00_01_C1);
    do_ack(x0, 1'b0);
    vectors++; if (load_n - l0 != 1 || load_val !== 16'h1000) begin miscompares++; $display("FAIL rst_next_load got %h want 1000", load_val); end
    vectors++; if (out_val !== 32'hBBCCDDEE || freq_val !== 32'h01000000) begin miscompares++; $display("FAIL rst_next_patterns got %h/%h want BBCCDDEE/01000000", out_val, freq_val); end
    vectors++; if (tx_val !== 8'hAC) begin miscompares++; $display("FAIL rst_next_ack got %h want AC", tx_val); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_stop;
    test_bad_ctrl;
    test_timeout;
    test_busy;
    test_inject;
    test_reset_mid;
    vectors++; if (both_n != 0) begin miscompares++; $display("FAIL load_and_stop got %0d overlapping cycles want 0", both_n); end
    vectors++; if (unstable_n != 0) begin miscompares++; $display("FAIL tx_data_stable got %0d changes want 0", unstable_n); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_pattern_cmd_ctrl.md
SERIAL_PATTERN_CMD_CTRL -- requirements
Module: serial_pattern_cmd_ctrl

Interface
REQ-001 SHALL have parameter PACK_NUM, default 9, meaning bytes per command packet.
REQ-002 SHALL have parameter DATA_BIT, default 32, meaning output-pattern and frequency-pattern width.
REQ-003 SHALL have parameter CH_NUM, default 16, meaning number of serial-out channels.
REQ-004 SHALL have parameter TIMEOUT_CLK, default 20000, meaning maximum idle clocks between bytes of one packet.
REQ-005 SHALL have port clk, input, 1, meaning system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have port i_data, input, 8, meaning UART RX byte, valid when i_rx_done_tick=1.
REQ-008 SHALL have port i_rx_done_tick, input, 1, meaning one-clock RX byte strobe.
REQ-009 SHALL have port i_busy, input, CH_NUM, meaning per-channel transmission-in-progress flags.
REQ-010 SHALL have port o_load, output, CH_NUM, meaning one-hot, one-clock channel load strobe.
REQ-011 SHALL have port o_stop, output, CH_NUM, meaning one-hot, one-clock channel stop strobe.
REQ-012 SHALL have port o_out_pattern, output, DATA_BIT, meaning output pattern for the loaded channel.
REQ-013 SHALL have port o_freq_pattern, output, DATA_BIT, meaning frequency pattern (0 = low period, 1 = high period per bit).
REQ-014 SHALL have port o_mode, output, 1, meaning 0 = one-shot, 1 = repeat.
REQ-015 SHALL have port o_tx_start, output, 1, meaning one-clock UART TX start strobe.
REQ-016 SHALL have port o_tx_data, output, 8, meaning acknowledge byte.
REQ-017 SHALL have port i_tx_done_tick, input, 1, meaning UART TX byte complete.
REQ-018 SHALL have port o_err_tick, output, 1, meaning one-clock error pulse.

Function
REQ-019 SHALL implement FSM states IDLE, RECV, DECODE, WAIT_CH, DISPATCH, ACK, ACK_WAIT.
REQ-020 SHALL map packet bytes little-endian: bytes 0-3 -> out_pattern[7:0]..[31:24], bytes 4-7 -> freq_pattern[7:0]..[31:24], byte 8 -> control.
REQ-021 SHALL decode control as [7:4] channel, [3] reserved (must be 0), [2] mode, [1:0] cmd: 01 LOAD, 10 STOP, others invalid.
REQ-022 SHALL move IDLE->RECV on the first i_rx_done_tick (byte 0 stored); RECV->DECODE on the cycle after byte PACK_NUM-1 is stored.
REQ-023 SHALL count idle clocks in RECV, clearing on each byte; at TIMEOUT_CLK, discard the partial packet, pulse o_err_tick, return to IDLE, no ack.
REQ-024 SHALL, in DECODE: invalid cmd, reserved bit=1, or channel >= CH_NUM -> ACK with error byte; STOP -> DISPATCH; LOAD -> WAIT_CH.
REQ-025 SHALL hold in WAIT_CH while i_busy[channel]=1, go DISPATCH the cycle after it reads 0.
REQ-026 SHALL, in DISPATCH, assert exactly one bit of o_load (LOAD) or o_stop (STOP) for one clock, with o_out_pattern, o_freq_pattern, o_mode stable that cycle and held until the next dispatch.
REQ-027 SHALL, in ACK, pulse o_tx_start one clock with o_tx_data = 8'hA0|channel (success) or 8'hE0|channel[3:0] (error); then ACK_WAIT until i_tx_done_tick -> IDLE.
REQ-028 SHALL give LOAD latency, channel idle: last byte tick at cycle N -> o_load at N+3 -> o_tx_start at N+4.
REQ-029 SHALL drop any byte arriving in DECODE..ACK_WAIT and pulse o_err_tick that cycle; the byte SHALL not start a new packet.
REQ-030 SHALL keep o_tx_data stable from o_tx_start until i_tx_done_tick.
REQ-031 SHALL never assert o_load and o_stop in the same cycle.

Reset
REQ-032 SHALL, while rst_n=1, force IDLE, clear the byte counter, timeout counter, o_load, o_stop, o_out_pattern, o_freq_pattern, o_mode, o_tx_start, o_tx_data, o_err_tick to 0.
REQ-033 SHALL, on reset mid-packet or mid-WAIT_CH, discard the packet with no dispatch and no ack after release.

Verification
REQ-034 SHALL pass: bytes 55 00 55 00 00 00 00 00 15, i_busy=0 -> o_load=16'h0002, o_out_pattern=32'h00550055, o_freq_pattern=0, o_mode=1, o_tx_data=8'hA1.
REQ-035 SHALL pass: same packet with control 8'hF6 -> o_stop=16'h8000, no o_load, o_tx_data=8'hAF.
REQ-036 SHALL pass: control 8'h2D (reserved bit set) -> no strobe, o_tx_data=8'hE2.
REQ-037 SHALL pass: 5 bytes then silence of TIMEOUT_CLK clocks -> one o_err_tick, IDLE, next full packet decoded correctly from byte 0.
REQ-038 SHALL pass: LOAD for channel 3 with i_busy[3]=1 for 500 clocks -> o_load[3] exactly one cycle after i_busy[3] falls, then ack 8'hA3.
REQ-039 SHALL pass: byte injected during ACK_WAIT -> o_err_tick pulse, byte ignored; subsequent packet handled normally.
